// File: rtl/mips_pipe_pkg.sv
// Shared constants, stage-state encoding and pipeline register bundles for the
// MEM stage of the pipelined MIPS CPU.
package mips_pipe_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 4;
    localparam int REG_AW    = 3;
    localparam int MEM_DEPTH = 10;

    typedef enum logic [1:0] {
        WAIT_LOAD,
        RUN,
        HALT
    } stage_state_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
        logic [REG_AW-1:0] src_reg;
        logic [REG_AW-1:0] rd;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
    } em_bundle_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } mw_bundle_t;

endpackage

// File: rtl/mem_range_check.sv
// Combinational guard for the data memory: flags effective addresses outside
// the populated words, comparing the full-width address before any truncation.
import mips_pipe_pkg::*;

module mem_range_check (
    input  logic [DATA_W-1:0] addr,
    input  logic              valid,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              in_range,
    output logic              fault_req
);

    assign in_range  = addr < DATA_W'(MEM_DEPTH);
    assign fault_req = valid && (mem_read || mem_write) && !in_range;

endmodule

// File: rtl/mem_stage_pipe.sv
// EX/MEM and MEM/WB pipeline registers around the data memory, with range
// fault handling. Optional feature macro: MEM_STORE_FWD_EN (load-to-store data forwarding).
import mips_pipe_pkg::*;

module mem_stage_pipe (
    input  logic              clk,
    input  logic              clr,
    input  logic              mem_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_AW-1:0] ex_src_reg,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic              load_in_mem,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              fault,
    output logic [DATA_W-1:0] fault_addr
);

    stage_state_t state, state_nxt;
    em_bundle_t   em_q, ex_in;
    mw_bundle_t   mw_q;
    logic         run, advance, in_range, fault_req, fault_take;

    mem_range_check u_range (
        .addr      (em_q.alu_result),
        .valid     (em_q.valid),
        .mem_read  (em_q.mem_read),
        .mem_write (em_q.mem_write),
        .in_range  (in_range),
        .fault_req (fault_req)
    );

    assign ex_in = '{valid:      ex_valid,
                     alu_result: ex_alu_result,
                     store_data: ex_store_data,
                     src_reg:    ex_src_reg,
                     rd:         ex_rd,
                     mem_read:   ex_mem_read,
                     mem_write:  ex_mem_write,
                     reg_write:  ex_reg_write};

    assign run        = (state == RUN);
    assign advance    = run && !stall;
    assign fault_take = advance && fault_req;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= WAIT_LOAD;
        else     state <= state_nxt;
    end

    // HALT is terminal; only clr brings the stage back to waiting for memory load.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_LOAD: if (mem_ready) state_nxt = RUN;
            RUN:       if (fault_take) state_nxt = HALT;
            default:   state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            em_q <= '0;
        end else if (advance) begin
            if (flush) em_q.valid <= 1'b0;
            else       em_q       <= ex_in;
        end
    end

    // A faulting access is dropped here so it never reaches write-back.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mw_q <= '0;
        end else if (advance) begin
            mw_q.valid     <= em_q.valid && !fault_req;
            mw_q.reg_write <= em_q.reg_write;
            mw_q.rd        <= em_q.rd;
            mw_q.data      <= em_q.mem_read ? mem_rdata : em_q.alu_result;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else if (fault_take) begin
            fault      <= 1'b1;
            fault_addr <= em_q.alu_result;
        end
    end

    assign mem_addr  = em_q.alu_result[ADDR_W-1:0];
    assign mem_write = advance && em_q.valid && em_q.mem_write && in_range;

`ifdef MEM_STORE_FWD_EN
    logic store_fwd_hit;
    assign store_fwd_hit = mw_q.valid && mw_q.reg_write && (mw_q.rd != '0)
                           && (mw_q.rd == em_q.src_reg);
    assign mem_wdata     = store_fwd_hit ? mw_q.data : em_q.store_data;
`else
    // Without forwarding the store source index is carried but not consumed here.
    logic unused_src_reg;
    assign unused_src_reg = ^em_q.src_reg;
    assign mem_wdata      = em_q.store_data;
`endif

    assign fwd_valid    = em_q.valid && em_q.reg_write && !em_q.mem_read;
    assign fwd_rd       = em_q.rd;
    assign fwd_data     = em_q.alu_result;
    assign load_in_mem  = em_q.valid && em_q.mem_read;

    assign wb_valid     = advance && mw_q.valid;
    assign wb_reg_write = mw_q.valid && mw_q.reg_write && (mw_q.rd != '0);
    assign wb_rd        = mw_q.rd;
    assign wb_data      = mw_q.data;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed-vector bench for mem_stage_pipe with a behavioural 16-word data memory
// that samples writes on the falling clock edge.
module tb_mem_stage_pipe;

    logic        clk = 1'b0;
    logic        clr, mem_ready, stall, flush;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [15:0] ex_alu_result, ex_store_data, mem_rdata;
    logic [2:0]  ex_src_reg, ex_rd;
    logic [3:0]  mem_addr;
    logic        mem_write, fwd_valid, load_in_mem, wb_valid, wb_reg_write, fault;
    logic [15:0] mem_wdata, fwd_data, wb_data, fault_addr;
    logic [2:0]  fwd_rd, wb_rd;

    logic [15:0] mem_model [0:15];
    int          write_count = 0;
    int          n_compared = 0;
    int          n_mismatched = 0;
    int          wc0;
    logic [15:0] exp_wdata;

    always #5 clk = ~clk;

    mem_stage_pipe dut (
        .clk(clk), .clr(clr), .mem_ready(mem_ready), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_src_reg(ex_src_reg), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .load_in_mem(load_in_mem), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault), .fault_addr(fault_addr)
    );

    assign mem_rdata = mem_model[mem_addr];

    always @(negedge clk) begin
        if (mem_write) begin
            mem_model[mem_addr] <= mem_wdata;
            write_count         <= write_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                                 input logic [2:0] src, input logic [2:0] rd,
                                 input logic mr, input logic mw, input logic rw);
        ex_valid      = v;
        ex_alu_result = alu;
        ex_store_data = sd;
        ex_src_reg    = src;
        ex_rd         = rd;
        ex_mem_read   = mr;
        ex_mem_write  = mw;
        ex_reg_write  = rw;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 16'h0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_model[i] = 16'h0;
        clr = 1'b1; mem_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        applyIdle();
        #2;
        checkOutput("rst_fault", fault, 0);
        checkOutput("rst_fault_addr", fault_addr, 0);
        checkOutput("rst_mem_write", mem_write, 0);
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_load_in_mem", load_in_mem, 0);
        checkOutput("rst_fwd_valid", fwd_valid, 0);
        #6 clr = 1'b0;

        // Memory still loading: a store presented now must not reach memory.
        applyStimulus(1'b1, 16'd3, 16'h00AA, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("wait_mem_write", mem_write, 0);
            checkOutput("wait_wb_valid", wb_valid, 0);
        end
        mem_ready = 1'b1;
        tick();
        checkOutput("run_entry_mem_write", mem_write, 0);
        wc0 = write_count;
        tick();
        checkOutput("sw3_mem_write", mem_write, 1);
        checkOutput("sw3_addr", mem_addr, 3);
        checkOutput("sw3_wdata", mem_wdata, 16'h00AA);
        applyIdle();
        tick();
        checkOutput("sw3_write_done", mem_write, 0);
        checkOutput("sw3_write_count", write_count - wc0, 1);
        checkOutput("sw3_wb_valid", wb_valid, 1);
        checkOutput("sw3_wb_reg_write", wb_reg_write, 0);

        // Store then load of the same word.
        applyStimulus(1'b1, 16'd5, 16'h1234, 3'd4, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("sw5_mem_write", mem_write, 1);
        checkOutput("sw5_addr", mem_addr, 5);
        applyStimulus(1'b1, 16'd5, 16'h0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("lw5_mem_write", mem_write, 0);
        checkOutput("lw5_load_in_mem", load_in_mem, 1);
        checkOutput("lw5_fwd_valid", fwd_valid, 0);
        applyIdle();
        tick();
        checkOutput("lw5_wb_valid", wb_valid, 1);
        checkOutput("lw5_wb_rd", wb_rd, 2);
        checkOutput("lw5_wb_data", wb_data, 16'h1234);
        checkOutput("lw5_wb_reg_write", wb_reg_write, 1);

        // ALU result forwarding and suppression of r0 writes.
        applyStimulus(1'b1, 16'h0042, 16'h0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("alu_fwd_valid", fwd_valid, 1);
        checkOutput("alu_fwd_rd", fwd_rd, 5);
        checkOutput("alu_fwd_data", fwd_data, 16'h0042);
        applyStimulus(1'b1, 16'h0077, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("alu_wb_data", wb_data, 16'h0042);
        checkOutput("alu_wb_rd", wb_rd, 5);
        checkOutput("alu_wb_reg_write", wb_reg_write, 1);
        applyIdle();
        tick();
        checkOutput("r0_wb_valid", wb_valid, 1);
        checkOutput("r0_wb_reg_write", wb_reg_write, 0);

        // Load r3 then immediately store r3.
        applyStimulus(1'b1, 16'd7, 16'hBEEF, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 16'd7, 16'h0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 16'd2, 16'h0BAD, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
`ifdef MEM_STORE_FWD_EN
        exp_wdata = 16'hBEEF;
`else
        exp_wdata = 16'h0BAD;
`endif
        checkOutput("fwd_sw_wdata", mem_wdata, exp_wdata);
        checkOutput("fwd_sw_addr", mem_addr, 2);
        checkOutput("fwd_sw_mem_write", mem_write, 1);
        applyIdle();
        tick();
        checkOutput("fwd_sw_mem2", mem_model[2], exp_wdata);

        // Store held by a 3-cycle stall.
        wc0 = write_count;
        applyStimulus(1'b1, 16'd1, 16'h5555, 3'd6, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        stall = 1'b1;
        applyIdle();
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_mem_write", mem_write, 0);
            checkOutput("stall_wb_valid", wb_valid, 0);
            tick();
        end
        checkOutput("stall_end_mem_write", mem_write, 0);
        stall = 1'b0;
        #1;
        checkOutput("release_mem_write", mem_write, 1);
        checkOutput("release_addr", mem_addr, 1);
        tick();
        checkOutput("release_done", mem_write, 0);
        checkOutput("stall_write_count", write_count - wc0, 1);
        checkOutput("stall_mem1", mem_model[1], 16'h5555);

        // Stall beats flush, then flush alone squashes.
        applyStimulus(1'b1, 16'h0011, 16'h0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h0022, 16'h0, 3'd0, 3'd6, 1'b0, 1'b0, 1'b1);
        stall = 1'b1; flush = 1'b1;
        tick();
        checkOutput("stflush_fwd_data", fwd_data, 16'h0011);
        checkOutput("stflush_fwd_rd", fwd_rd, 1);
        checkOutput("stflush_fwd_valid", fwd_valid, 1);
        stall = 1'b0;
        tick();
        checkOutput("flush_fwd_valid", fwd_valid, 0);
        checkOutput("flush_wb_data", wb_data, 16'h0011);
        flush = 1'b0;
        applyIdle();
        tick();
        checkOutput("flush_bubble_wb_valid", wb_valid, 0);

        // Last legal word, then first illegal one.
        applyStimulus(1'b1, 16'd9, 16'h0999, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("sw9_mem_write", mem_write, 1);
        applyStimulus(1'b1, 16'd9, 16'h0, 3'd0, 3'd4, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("lw9_fault", fault, 0);
        applyStimulus(1'b1, 16'd10, 16'h0, 3'd0, 3'd5, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("lw9_wb_data", wb_data, 16'h0999);
        checkOutput("lw9_wb_rd", wb_rd, 4);
        checkOutput("lw10_fault_pre", fault, 0);
        applyIdle();
        tick();
        checkOutput("lw10_fault", fault, 1);
        checkOutput("lw10_fault_addr", fault_addr, 16'h000A);
        checkOutput("lw10_wb_valid", wb_valid, 0);
        applyStimulus(1'b1, 16'd0, 16'h1111, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("halt_mem_write", mem_write, 0);
        checkOutput("halt_wb_valid", wb_valid, 0);
        checkOutput("halt_fault_sticky", fault, 1);

        // Reset out of HALT, then a wrapped address must still fault.
        clr = 1'b1;
        mem_ready = 1'b0;
        #1;
        checkOutput("clr_fault", fault, 0);
        checkOutput("clr_fault_addr", fault_addr, 0);
        checkOutput("clr_wb_valid", wb_valid, 0);
        clr = 1'b0;
        applyStimulus(1'b1, 16'hFFFF, 16'h2222, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("clr_wait_mem_write", mem_write, 0);
        checkOutput("clr_wait_fwd_valid", fwd_valid, 0);
        mem_ready = 1'b1;
        tick();
        tick();
        checkOutput("ffff_mem_write", mem_write, 0);
        checkOutput("ffff_fault_pre", fault, 0);
        applyIdle();
        tick();
        checkOutput("ffff_fault", fault, 1);
        checkOutput("ffff_fault_addr", fault_addr, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
